// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V load/store unit between a core request port and a single-word memory port
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_we, req_funct3, req_addr, req_wdata : core request
//   resp_valid, resp_rdata, resp_fault                          : one-cycle completion
//   mem_valid/mem_ready, mem_we, mem_addr, mem_wstrb, mem_wdata  : memory request
//   mem_rvalid, mem_rdata                                        : memory read return
//   LSU_MISALIGNED_SPLIT_EN: boundary-crossing accesses become two word accesses;
//   when undefined, any misaligned access faults without touching memory.
module load_store_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_fault,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    typedef enum logic [2:0] {IDLE, ACC1, WAIT1, ACC2, WAIT2, RESP} state_t;
    state_t state, state_nx;
    logic we_q, fault_q, two_q, legal, bad, two;
    logic [2:0] f3_q;
    logic [3:0] sz;
    logic [ADDR_W-1:0] addr_q, base;
    logic [XLEN-1:0] wdata_q, rd_lo, rd_hi, ld, lext;
    logic [2*XLEN-1:0] wd;
    logic [2*NB-1:0] ws;
    assign sz = 4'd1 << req_funct3[1:0];
    assign legal = req_we ? (req_funct3 <= 3'd2 || (XLEN == 64 && req_funct3 == 3'd3))
                          : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} ||
                             (XLEN == 64 && req_funct3 inside {3'd3, 3'd6}));
`ifdef LSU_MISALIGNED_SPLIT_EN
    // A second word is needed only when the bytes run past the end of the first word
    assign two = 5'(req_addr[OW-1:0]) + 5'(sz) > 5'(NB);
    assign bad = !legal;
`else
    logic mis;
    assign mis = (req_addr[OW-1:0] & OW'(sz - 4'd1)) != '0;
    assign two = 1'b0;
    assign bad = !legal || mis;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            two_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_lo   <= '0;
            rd_hi   <= '0;
        end else begin
            state <= state_nx;
            if (req_valid && req_ready) begin
                we_q    <= req_we;
                fault_q <= bad;
                two_q   <= two;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == WAIT1 && mem_rvalid) rd_lo <= mem_rdata;
            if (state == WAIT2 && mem_rvalid) rd_hi <= mem_rdata;
        end
    end
    always_comb begin
        case (state)
            IDLE:    state_nx = req_valid ? (bad ? RESP : ACC1) : IDLE;
            ACC1:    state_nx = mem_ready ? (we_q ? (two_q ? ACC2 : RESP) : WAIT1) : ACC1;
            WAIT1:   state_nx = mem_rvalid ? (two_q ? ACC2 : RESP) : WAIT1;
            ACC2:    state_nx = mem_ready ? (we_q ? RESP : WAIT2) : ACC2;
            WAIT2:   state_nx = mem_rvalid ? RESP : WAIT2;
            default: state_nx = IDLE;
        endcase
    end
    // Data and strobes are placed across a two-word window; ACC1 drives the low word, ACC2 the high
    assign base = {addr_q[ADDR_W-1:OW], OW'(0)};
    assign wd   = {XLEN'(0), wdata_q} << {addr_q[OW-1:0], 3'b000};
    assign ws   = (((2*NB)'(1) << (4'd1 << f3_q[1:0])) - (2*NB)'(1)) << addr_q[OW-1:0];
    assign ld   = XLEN'({rd_hi, rd_lo} >> {addr_q[OW-1:0], 3'b000});
    always_comb begin
        case (f3_q)
            3'd0:    lext = XLEN'($signed(ld[7:0]));
            3'd1:    lext = XLEN'($signed(ld[15:0]));
            3'd2:    lext = XLEN'($signed(ld[31:0]));
            3'd4:    lext = XLEN'(ld[7:0]);
            3'd5:    lext = XLEN'(ld[15:0]);
            3'd6:    lext = XLEN'(ld[31:0]);
            default: lext = ld;
        endcase
    end
    always_comb begin
        req_ready  = state == IDLE;
        mem_valid  = state == ACC1 || state == ACC2;
        mem_we     = mem_valid && we_q;
        mem_addr   = mem_valid ? base + (state == ACC2 ? ADDR_W'(NB) : '0) : '0;
        mem_wstrb  = mem_we ? (state == ACC2 ? ws[2*NB-1:NB] : ws[NB-1:0]) : '0;
        mem_wdata  = mem_we ? (state == ACC2 ? wd[2*XLEN-1:XLEN] : wd[XLEN-1:0]) : '0;
        resp_valid = state == RESP;
        resp_fault = resp_valid && fault_q;
        resp_rdata = resp_valid && !we_q && !fault_q ? lext : '0;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit (XLEN=32) with a stub memory responder
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    load_store_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; logic fault; int acc; int lat; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; } mem_t;
    resp_t exp_resp[$];
    mem_t  exp_mem[$];
    int checks = 0, failures = 0, cyc = 0, stall = 0, rd_delay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'ha0:  return 32'h44332211;
            32'ha4:  return 32'h88776655;
            32'ha8:  return 32'hc7d6e5f4;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // Memory responder: optional ready stall, read data returned rd_delay cycles after the minimum
    initial begin : responder
        logic busy, pend;
        int cnt, rwait;
        logic [31:0] raddr;
        logic [68:0] snap;
        mem_t m;
        busy = 0; pend = 0; cnt = 0; rwait = 0; raddr = 0; snap = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 0;
            mem_rvalid = 0;
            if (pend) begin
                rwait--;
                if (rwait == 0) begin
                    mem_rvalid = 1;
                    mem_rdata = word(raddr);
                    pend = 0;
                end
            end
            if (!mem_valid) busy = 0;
            else begin
                if (!busy) begin
                    busy = 1;
                    cnt = stall;
                    snap = {mem_we, mem_addr, mem_wstrb, mem_wdata};
                end else check("stall_stable", {mem_we, mem_addr, mem_wstrb, mem_wdata}, snap);
                if (cnt > 0) cnt--;
                else begin
                    mem_ready = 1;
                    busy = 0;
                    if (exp_mem.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mem_unexpected: got addr %0h we %b expected no access", mem_addr, mem_we);
                    end else begin
                        m = exp_mem.pop_front();
                        check("mem_we", mem_we, m.we);
                        check("mem_addr", mem_addr, m.addr);
                        if (m.we) begin
                            check("mem_wstrb", mem_wstrb, m.strb);
                            check("mem_wdata", mem_wdata & bmask(m.strb), m.wdata);
                        end
                    end
                    if (!mem_we) begin
                        pend = 1;
                        rwait = rd_delay + 1;
                        raddr = mem_addr;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        resp_t r;
        if (reset && resp_valid) begin
            if (exp_resp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected: got rdata %0h fault %b expected no response", resp_rdata, resp_fault);
            end else begin
                r = exp_resp.pop_front();
                check("resp_rdata", resp_rdata, r.rdata);
                check("resp_fault", resp_fault, r.fault);
                check("resp_latency", cyc - r.acc, r.lat);
            end
        end
    end

    task automatic exp_m(input logic we, input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
        exp_mem.push_back('{we, addr, strb, wd});
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_f, input int lat, input bit want = 1);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout: got req_ready 0 expected 1");
            return;
        end
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        if (want) exp_resp.push_back('{exp_rd, exp_f, cyc, lat});
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req_ready"}, req_ready, 1'b1);
        check({tag, "_mem_valid"}, mem_valid, 1'b0);
        check({tag, "_resp_valid"}, resp_valid, 1'b0);
        check({tag, "_resp_fault"}, resp_fault, 1'b0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        check({tag, "_mem_out"}, {mem_we, mem_addr, mem_wstrb, mem_wdata}, 69'h0);
    endtask

    initial begin
        int n;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset = 1;
        @(negedge clk);
        exp_m(0, 32'ha8, 4'h0, 32'h0);
        issue(0, 3'b000, 32'ha9, 32'h0, 32'hffffffe5, 0, 3);
        exp_m(0, 32'ha8, 4'h0, 32'h0);
        issue(0, 3'b101, 32'haa, 32'h0, 32'h0000c7d6, 0, 3);
        exp_m(0, 32'ha0, 4'h0, 32'h0);
        issue(0, 3'b001, 32'ha0, 32'h0, 32'h00002211, 0, 3);
        stall = 4;
        exp_m(0, 32'ha0, 4'h0, 32'h0);
        issue(0, 3'b010, 32'ha0, 32'h0, 32'h44332211, 0, 7);
        stall = 0;
        exp_m(0, 32'ha4, 4'h0, 32'h0);
        issue(0, 3'b000, 32'ha7, 32'h0, 32'hffffff88, 0, 3);
        exp_m(0, 32'ha4, 4'h0, 32'h0);
        issue(0, 3'b100, 32'ha7, 32'h0, 32'h00000088, 0, 3);
        exp_m(1, 32'ha0, 4'b1100, 32'hbeef0000);
        issue(1, 3'b001, 32'ha2, 32'h0000beef, 32'h0, 0, 2);
        exp_m(1, 32'ha4, 4'b0010, 32'h00005a00);
        issue(1, 3'b000, 32'ha5, 32'h0000005a, 32'h0, 0, 2);
        exp_m(1, 32'ha4, 4'b1111, 32'hdeadbeef);
        issue(1, 3'b010, 32'ha4, 32'hdeadbeef, 32'h0, 0, 2);
        issue(0, 3'b111, 32'ha0, 32'h0, 32'h0, 1, 1);
        issue(1, 3'b100, 32'ha0, 32'h12345678, 32'h0, 1, 1);
        issue(0, 3'b011, 32'ha0, 32'h0, 32'h0, 1, 1);
`ifdef LSU_MISALIGNED_SPLIT_EN
        exp_m(0, 32'ha0, 4'h0, 32'h0);
        exp_m(0, 32'ha4, 4'h0, 32'h0);
        issue(0, 3'b010, 32'ha2, 32'h0, 32'h66554433, 0, 5);
        exp_m(1, 32'ha0, 4'b0110, 32'h00beef00);
        issue(1, 3'b001, 32'ha1, 32'h0000beef, 32'h0, 0, 2);
        exp_m(1, 32'ha0, 4'b1100, 32'hf00d0000);
        exp_m(1, 32'ha4, 4'b0011, 32'h0000cafe);
        issue(1, 3'b010, 32'ha6, 32'hcafef00d, 32'h0, 0, 3);
`else
        issue(0, 3'b010, 32'ha2, 32'h0, 32'h0, 1, 1);
        issue(1, 3'b001, 32'ha1, 32'h0000beef, 32'h0, 1, 1);
        issue(1, 3'b010, 32'ha6, 32'hcafef00d, 32'h0, 1, 1);
`endif
        // Abort a load in WAIT1; its data arrives only after reset is released
        rd_delay = 6;
        exp_m(0, 32'ha0, 4'h0, 32'h0);
        issue(0, 3'b010, 32'ha0, 32'h0, 32'h0, 0, 0, 0);
        @(negedge clk);
        rd_delay = 0;
        reset = 0;
        @(negedge clk);
        check_idle("abort");
        reset = 1;
        repeat (10) @(negedge clk);
        check("abort_req_ready", req_ready, 1'b1);
        exp_m(0, 32'ha0, 4'h0, 32'h0);
        issue(0, 3'b100, 32'ha3, 32'h0, 32'h00000044, 0, 3);
        n = 0;
        while (exp_resp.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("resp_drained", exp_resp.size(), 0);
        check("mem_drained", exp_mem.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, SHALL set the byte-address width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid / req_ready  input / output  1 / 1  SHALL form the core request handshake; a request is accepted when both are high.
REQ-006 req_we, req_funct3, req_addr, req_wdata  input  1, 3, ADDR_W, XLEN  SHALL carry store flag, RISC-V funct3, byte address and store data.
REQ-007 resp_valid, resp_rdata, resp_fault  output  1, XLEN, 1  SHALL carry the completion pulse, load result and fault flag.
REQ-008 mem_valid / mem_ready  output / input  1 / 1  SHALL form the memory request handshake.
REQ-009 mem_we, mem_addr, mem_wstrb, mem_wdata  output  1, ADDR_W, XLEN/8, XLEN  SHALL carry the store flag, XLEN-aligned address, byte strobes and lane-positioned data.
REQ-010 mem_rvalid, mem_rdata  input  1, XLEN  SHALL return read data at least one cycle after a read is accepted.

Function
REQ-011 The loads lb/lh/lw/lbu/lhu SHALL be funct3 000/001/010/100/101; for XLEN=64 only, ld=011 and lwu=110 SHALL also be legal; the stores sb/sh/sw(/sd) SHALL be 000/001/010(/011).
REQ-012 Any other funct3 SHALL complete with resp_fault=1, resp_rdata=0 and no memory access.
REQ-013 The FSM states SHALL be IDLE, ACC1, WAIT1, ACC2, WAIT2, RESP; req_ready SHALL be high only in IDLE.
REQ-014 IDLE SHALL go to ACC1 on acceptance, latching all req_* fields; illegal or faulting requests SHALL go directly to RESP.
REQ-015 In ACC1/ACC2, mem_valid SHALL be high and all mem_* outputs SHALL stay stable until mem_ready is high.
REQ-016 An accepted store SHALL go to ACC2 if a second access is pending, else to RESP; an accepted read SHALL go to WAIT1/WAIT2.
REQ-017 WAIT1/WAIT2 SHALL capture mem_rdata on mem_rvalid; mem_rvalid outside WAIT states SHALL be ignored.
REQ-018 RESP SHALL last exactly one cycle with resp_valid=1 and SHALL then return to IDLE; there is no response back-pressure.
REQ-019 With zero memory wait states, an aligned load SHALL assert resp_valid 3 cycles after acceptance and an aligned store 2 cycles after acceptance.
REQ-020 Load data SHALL be the selected little-endian bytes, shifted to bit 0, sign-extended for lb/lh/lw(XLEN=64) and zero-extended for lbu/lhu/lwu.
REQ-021 Store data SHALL be replicated into the addressed byte lanes, with mem_wstrb covering exactly those bytes.
REQ-022 resp_rdata SHALL be 0 for stores and for faults.

Reset
REQ-023 While reset is low, the state SHALL be IDLE, mem_valid=0, resp_valid=0, resp_fault=0, resp_rdata=0, mem_* outputs=0 and req_ready=1.
REQ-024 Reset asserted mid-transaction SHALL abort it with no response; a late mem_rvalid SHALL be ignored.

Configuration
REQ-025 Macro LSU_MISALIGNED_SPLIT_EN defined: an access that crosses an XLEN-aligned boundary SHALL use two accesses.
- ACC1 at floor(addr), ACC2 at floor(addr)+XLEN/8.
- Strobes and data SHALL be split per word; loaded bytes SHALL be merged before extension.
- A misaligned access that does not cross a boundary SHALL use one access.
REQ-026 Macro LSU_MISALIGNED_SPLIT_EN undefined: any access with addr not a multiple of its size SHALL go directly to RESP with resp_fault=1 and no mem_valid; ACC2/WAIT2 SHALL be unreachable.

Verification (XLEN=32; word 0xa0=0x44332211, 0xa4=0x88776655, 0xa8=0xc7d6e5f4)
REQ-027 lb addr 0xa9 -> mem_addr 0xa8, resp_rdata 0xffffffe5, resp_fault 0, resp_valid 3 cycles after acceptance with zero wait states.
REQ-028 lhu 0xaa -> 0x0000c7d6; lh 0xa0 -> 0x00002211; lw 0xa0 with mem_ready delayed 4 cycles -> 0x44332211, mem_* outputs stable throughout the stall.
REQ-029 sh 0xa2 with wdata 0x0000beef -> mem_addr 0xa0, mem_wstrb 4'b1100, mem_wdata bits[31:16]=0xbeef; funct3 111 -> resp_fault 1 and no mem_valid.
REQ-030 lw 0xa2 -> with LSU_MISALIGNED_SPLIT_EN: accesses to 0xa0 then 0xa4, resp_rdata 0x66554433; without: resp_fault 1, no mem_valid.
REQ-031 reset low during WAIT1, then mem_rvalid pulsed after reset goes high -> no resp_valid, req_ready 1, and the next lbu 0xa3 -> 0x00000044.
